// File: rtl/rvcpu_pkg.sv
// Shared constants and types for the UART memory loader: memory size codes,
// command opcodes, response codes and the loader state encoding.
package rvcpu_pkg;

  localparam logic [2:0] MEM_NONE = 3'b000;
  localparam logic [2:0] MEM_DW   = 3'b100;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    MEM,
    RESP
  } loader_state_t;

  function automatic logic is_valid_opcode(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/loader_shift8.sv
// Eight-byte little-endian register: bytes shift in at the top so the first
// byte lands in [7:0], and shift out from the bottom for serialization.
module loader_shift8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] load_value,
  input  logic        shift_in,
  input  logic [7:0]  in_byte,
  input  logic        shift_out,
  output logic [63:0] value,
  output logic [7:0]  low_byte
);

  // Load wins over shifting; the two shift directions are never used together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (shift_in) begin
      value <= {in_byte, value[63:8]};
    end else if (shift_out) begin
      value <= {8'h00, value[63:8]};
    end
  end

  assign low_byte = value[7:0];

endmodule

// File: rtl/uart_loader.sv
// UART command responder that reads/writes doublewords on the memory port.
// Optional inter-byte timeout enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_loader #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_din,
  input  logic [63:0] mem_dout,
  output logic [2:0]  mem_rd_ctrl,
  output logic [2:0]  mem_wr_ctrl,
  input  logic        mem_ready,
  output logic        cpu_hold,
  output logic        rx_overrun
);

  import rvcpu_pkg::*;

  loader_state_t state_q, state_d;

  logic [2:0]  cnt_q;
  logic        is_write_q;
  logic        resp_long_q;
  logic        overrun_q;

  logic        addr_shift;
  logic        data_shift;
  logic        byte_in;
  logic        tx_fire;
  logic        last_byte;
  logic        misaligned;
  logic        resp_done;
  logic        timeout;

  logic        resp_load;
  logic [63:0] resp_load_value;
  logic [63:0] addr_value;
  logic [63:0] data_value;
  logic [7:0]  resp_byte;
  logic [7:0]  addr_low_unused;
  logic [7:0]  data_low_unused;
  logic [63:0] resp_word_unused;

  assign addr_shift = rx_valid && (state_q == ADDR);
  assign data_shift = rx_valid && (state_q == DATA);
  assign byte_in    = addr_shift || data_shift;
  assign tx_fire    = (state_q == RESP) && tx_ready;
  assign last_byte  = (cnt_q == 3'd7);
  // Seven bytes are in, so the first (least significant) byte sits in [15:8].
  assign misaligned = (addr_value[10:8] != 3'b000);
  assign resp_done  = resp_long_q ? last_byte : 1'b1;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (byte_in || !((state_q == ADDR) || (state_q == DATA))) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign timeout = ((state_q == ADDR) || (state_q == DATA)) &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A received byte always takes precedence over the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          state_d = is_valid_opcode(rx_data) ? ADDR : RESP;
        end
      end
      ADDR: begin
        if (rx_valid) begin
          if (last_byte) begin
            if (misaligned) begin
              state_d = RESP;
            end else begin
              state_d = is_write_q ? DATA : MEM;
            end
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (last_byte) begin
            state_d = MEM;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      MEM: begin
        if (mem_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (tx_fire && resp_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_valid    = (state_q == RESP);
    tx_data     = (state_q == RESP) ? resp_byte : 8'h00;
    mem_rd_ctrl = MEM_NONE;
    mem_wr_ctrl = MEM_NONE;
    if (state_q == MEM) begin
      if (is_write_q) begin
        mem_wr_ctrl = MEM_DW;
      end else begin
        mem_rd_ctrl = MEM_DW;
      end
    end
    cpu_hold = (state_q != IDLE);
  end

  // NAK is queued for bad opcodes and misaligned addresses, ACK/read data from MEM.
  always_comb begin
    resp_load       = 1'b0;
    resp_load_value = {56'h0, RESP_NAK};
    unique case (state_q)
      IDLE: begin
        if (rx_valid && !is_valid_opcode(rx_data)) begin
          resp_load = 1'b1;
        end
      end
      ADDR: begin
        if (rx_valid && last_byte && misaligned) begin
          resp_load = 1'b1;
        end
      end
      MEM: begin
        if (mem_ready) begin
          resp_load       = 1'b1;
          resp_load_value = is_write_q ? {56'h0, RESP_ACK} : mem_dout;
        end
      end
      default: resp_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 3'd0;
      is_write_q  <= 1'b0;
      resp_long_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        cnt_q <= 3'd0;
      end else if (byte_in || tx_fire) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if ((state_q == IDLE) && rx_valid) begin
        is_write_q <= (rx_data == OP_WRITE);
      end
      if (resp_load) begin
        resp_long_q <= (state_q == MEM) && !is_write_q;
      end
      if (rx_valid && ((state_q == MEM) || (state_q == RESP))) begin
        overrun_q <= 1'b1;
      end
    end
  end

  loader_shift8 u_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (1'b0),
    .load_value (64'h0),
    .shift_in   (addr_shift),
    .in_byte    (rx_data),
    .shift_out  (1'b0),
    .value      (addr_value),
    .low_byte   (addr_low_unused)
  );

  loader_shift8 u_data (
    .clk        (clk),
    .rst        (rst),
    .load       (1'b0),
    .load_value (64'h0),
    .shift_in   (data_shift),
    .in_byte    (rx_data),
    .shift_out  (1'b0),
    .value      (data_value),
    .low_byte   (data_low_unused)
  );

  loader_shift8 u_resp (
    .clk        (clk),
    .rst        (rst),
    .load       (resp_load),
    .load_value (resp_load_value),
    .shift_in   (1'b0),
    .in_byte    (8'h00),
    .shift_out  (tx_fire),
    .value      (resp_word_unused),
    .low_byte   (resp_byte)
  );

  assign mem_addr   = addr_value;
  assign mem_din    = data_value;
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed vector table, reset/overrun
// and optional timeout sequences, then random frames against a memory model.
module tb_uart_loader;

  import rvcpu_pkg::*;

  localparam int TMO = 16;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    logic        preload;
    logic [63:0] rd_value;
    int          delay;
    int          mode;
    logic        inject;
    int          exp_len;
    logic [63:0] exp_resp;
    int          exp_req;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [63:0] mem_addr;
  logic [63:0] mem_din;
  logic [63:0] mem_dout = 64'h0;
  logic [2:0]  mem_rd_ctrl;
  logic [2:0]  mem_wr_ctrl;
  logic        mem_ready = 1'b0;
  logic        cpu_hold;
  logic        rx_overrun;

  int checks = 0;
  int errors = 0;

  int          ready_mode = 0;
  int          mem_delay = 0;
  logic        rd_override_en = 1'b0;
  logic [63:0] rd_override_val = 64'h0;

  logic [7:0]  tx_q[$];
  logic        hold_at_accept = 1'b0;

  logic [63:0] store [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];
  logic        mem_busy = 1'b0;
  int          mem_wait = 0;
  int          req_count = 0;
  int          req_cycles = 0;
  logic [63:0] req_addr = 64'h0;
  logic [63:0] req_din = 64'h0;
  logic        req_wr = 1'b0;
  logic        req_rd = 1'b0;

  vec_t vecs[7];
  vec_t rv;
  int   kind;
  int   cyc;

  uart_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .mem_rd_ctrl (mem_rd_ctrl),
    .mem_wr_ctrl (mem_wr_ctrl),
    .mem_ready   (mem_ready),
    .cpu_hold    (cpu_hold),
    .rx_overrun  (rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Transmitter: choose tx_ready for the coming edge, then log the handshake it makes.
  always @(negedge clk) begin
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    if (!rst && tx_valid && tx_ready) begin
      tx_q.push_back(tx_data);
      hold_at_accept = cpu_hold;
    end
  end

  // Memory: answers mem_delay cycles after a request appears, checks stability.
  always @(negedge clk) begin
    if (rst || (mem_rd_ctrl == MEM_NONE && mem_wr_ctrl == MEM_NONE)) begin
      mem_busy  = 1'b0;
      mem_ready = 1'b0;
      mem_dout  = {$urandom, $urandom};
    end else begin
      if (!mem_busy) begin
        mem_busy   = 1'b1;
        mem_wait   = 0;
        req_cycles = 0;
        req_count++;
        req_addr = mem_addr;
        req_din  = mem_din;
        req_wr   = (mem_wr_ctrl == MEM_DW);
        req_rd   = (mem_rd_ctrl == MEM_DW);
      end else begin
        check_output("mem_addr_stable", mem_addr, req_addr);
        check_output("mem_din_stable", mem_din, req_din);
      end
      req_cycles++;
      if (mem_wait == mem_delay) begin
        mem_ready = 1'b1;
        if (req_wr) store[req_addr] = req_din;
        if (rd_override_en) mem_dout = rd_override_val;
        else if (store.exists(req_addr)) mem_dout = store[req_addr];
        else mem_dout = 64'h0;
      end else begin
        mem_ready = 1'b0;
        mem_dout  = {$urandom, $urandom};
      end
      mem_wait++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input int limit, output int cycles);
    cycles = 0;
    while (cpu_hold && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    if (cpu_hold) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle: cpu_hold still 1 after %0d cycles, expected 0", limit);
    end
  endtask

  task automatic wait_mem(input int limit);
    int n;
    n = 0;
    while (mem_rd_ctrl == MEM_NONE && mem_wr_ctrl == MEM_NONE && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (mem_rd_ctrl == MEM_NONE && mem_wr_ctrl == MEM_NONE) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_mem: no memory request after %0d cycles, expected one", limit);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output($sformatf("%s tx_valid", tag), tx_valid, 1'b0);
    check_output($sformatf("%s tx_data", tag), tx_data, 8'h00);
    check_output($sformatf("%s mem_rd_ctrl", tag), mem_rd_ctrl, MEM_NONE);
    check_output($sformatf("%s mem_wr_ctrl", tag), mem_wr_ctrl, MEM_NONE);
    check_output($sformatf("%s mem_addr", tag), mem_addr, 64'h0);
    check_output($sformatf("%s mem_din", tag), mem_din, 64'h0);
    check_output($sformatf("%s cpu_hold", tag), cpu_hold, 1'b0);
    check_output($sformatf("%s rx_overrun", tag), rx_overrun, 1'b0);
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    int   base_tx;
    int   base_req;
    int   n;
    logic exp_wr;
    base_tx  = tx_q.size();
    base_req = req_count;
    exp_wr   = (v.op == OP_WRITE);
    ready_mode      = v.mode;
    mem_delay       = v.delay;
    rd_override_en  = v.preload;
    rd_override_val = v.rd_value;
    send_byte(v.op);
    if (v.op == OP_WRITE || v.op == OP_READ) begin
      for (int i = 0; i < 8; i++) send_byte(v.addr[8*i +: 8]);
      if (exp_wr && v.addr[2:0] == 3'b000) begin
        for (int i = 0; i < 8; i++) send_byte(v.data[8*i +: 8]);
      end
    end
    if (v.inject) begin
      wait_mem(20);
      send_byte(8'hAA);
      check_output($sformatf("%s rx_overrun", tag), rx_overrun, 1'b1);
    end
    wait_idle(400, n);
    check_output($sformatf("%s tx_len", tag), tx_q.size() - base_tx, v.exp_len);
    for (int i = 0; i < v.exp_len && base_tx + i < tx_q.size(); i++) begin
      check_output($sformatf("%s tx_byte%0d", tag, i), tx_q[base_tx + i], v.exp_resp[8*i +: 8]);
    end
    check_output($sformatf("%s mem_requests", tag), req_count - base_req, v.exp_req);
    if (v.exp_req != 0 && req_count != base_req) begin
      check_output($sformatf("%s req_addr", tag), req_addr, v.addr);
      check_output($sformatf("%s req_wr", tag), req_wr, exp_wr);
      check_output($sformatf("%s req_rd", tag), req_rd, !exp_wr);
      check_output($sformatf("%s req_cycles", tag), req_cycles, v.delay + 1);
      if (exp_wr) check_output($sformatf("%s req_din", tag), req_din, v.data);
    end
    if (tx_q.size() > base_tx) begin
      check_output($sformatf("%s hold_at_last_tx", tag), hold_at_accept, 1'b1);
    end
  endtask

  initial begin
    vecs[0] = '{OP_WRITE, 64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788, 1'b0, 64'h0,
                3, 0, 1'b0, 1, 64'h06, 1};
    vecs[1] = '{OP_READ, 64'h0000_0000_8000_0010, 64'h0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D,
                2, 1, 1'b0, 8, 64'hDEAD_BEEF_CAFE_F00D, 1};
    vecs[2] = '{8'h41, 64'h0, 64'h0, 1'b0, 64'h0, 0, 0, 1'b0, 1, 64'h15, 0};
    vecs[3] = '{OP_READ, 64'h0000_0000_8000_0013, 64'h0, 1'b0, 64'h0,
                0, 0, 1'b0, 1, 64'h15, 0};
    vecs[4] = '{OP_READ, 64'h0000_0000_0000_0008, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF,
                0, 2, 1'b0, 8, 64'h0123_4567_89AB_CDEF, 1};
    vecs[5] = '{OP_READ, 64'h0000_0000_8000_0020, 64'h0, 1'b1, 64'h0F1E_2D3C_4B5A_6978,
                6, 0, 1'b1, 8, 64'h0F1E_2D3C_4B5A_6978, 1};
    vecs[6] = '{OP_WRITE, 64'h0000_0000_8000_0028, 64'hA5A5_0000_FFFF_1234, 1'b0, 64'h0,
                1, 2, 1'b0, 1, 64'h06, 1};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    check_output("overrun_sticky", rx_overrun, 1'b1);

`ifdef UART_LOADER_TIMEOUT_EN
    begin
      int base_tx;
      int base_req;
      base_tx  = tx_q.size();
      base_req = req_count;
      ready_mode = 0;
      send_byte(OP_WRITE);
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'h00);
      wait_idle(100, cyc);
      check_output("timeout cycles", cyc, TMO);
      check_output("timeout cpu_hold", cpu_hold, 1'b0);
      check_output("timeout tx_len", tx_q.size() - base_tx, 0);
      check_output("timeout mem_requests", req_count - base_req, 0);
    end
`endif

    // Reset while the write is waiting for memory: request and frame vanish.
    begin
      int base_tx;
      logic [63:0] a;
      a = 64'h0000_0000_8000_0030;
      base_tx = tx_q.size();
      ready_mode = 0;
      mem_delay = 40;
      rd_override_en = 1'b0;
      send_byte(OP_WRITE);
      for (int i = 0; i < 8; i++) send_byte(a[8*i +: 8]);
      for (int i = 0; i < 8; i++) send_byte(8'h5A);
      wait_mem(20);
      check_output("rst_in_mem wr_ctrl_before", mem_wr_ctrl, MEM_DW);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_in_mem");
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_output("rst_in_mem tx_len", tx_q.size() - base_tx, 0);
      check_output("rst_in_mem cpu_hold", cpu_hold, 1'b0);
      check_output("rst_in_mem no_write", store.exists(a), 1'b0);
    end

    rv = '{OP_READ, 64'h0000_0000_8000_0010, 64'h0, 1'b0, 64'h0,
           2, 1, 1'b0, 8, 64'h1122_3344_5566_7788, 1};
    apply_stimulus(rv, "readback");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      rv.addr     = 64'h0000_0000_9000_0000 + 64'($urandom_range(0, 7)) * 64'd8;
      rv.data     = {$urandom, $urandom};
      rv.preload  = 1'b0;
      rv.rd_value = 64'h0;
      rv.delay    = $urandom_range(0, 4);
      rv.mode     = $urandom_range(0, 2);
      rv.inject   = 1'b0;
      if (kind <= 3) begin
        rv.op = OP_WRITE;
      end else if (kind <= 7) begin
        rv.op = OP_READ;
      end else if (kind == 8) begin
        rv.op = 8'($urandom_range(0, 255));
        if (rv.op == OP_WRITE || rv.op == OP_READ) rv.op = 8'h00;
      end else begin
        rv.op = ($urandom_range(0, 1) == 1) ? OP_WRITE : OP_READ;
        rv.addr[2:0] = 3'($urandom_range(1, 7));
      end
      if ((rv.op != OP_WRITE && rv.op != OP_READ) || rv.addr[2:0] != 3'b000) begin
        rv.exp_len  = 1;
        rv.exp_resp = {56'h0, RESP_NAK};
        rv.exp_req  = 0;
      end else if (rv.op == OP_WRITE) begin
        ref_mem[rv.addr] = rv.data;
        rv.exp_len  = 1;
        rv.exp_resp = {56'h0, RESP_ACK};
        rv.exp_req  = 1;
      end else begin
        rv.exp_len  = 8;
        rv.exp_resp = ref_mem.exists(rv.addr) ? ref_mem[rv.addr] : 64'h0;
        rv.exp_req  = 1;
      end
      apply_stimulus(rv, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
